// File: rtl/hexled_scan.sv
// hexled_scan: time-multiplexed hex display driver with per-slot anti-ghost blanking.
// Define HEXLED_SCAN_LZS_EN to enable leading-zero suppression of the displayed value.
module hexled_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [4*NUM_DIGITS-1:0] i_data,
  input  logic                    i_load,
  input  logic [NUM_DIGITS-1:0]   i_blank,
  output logic [6:0]              o_seg,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic                    o_slot_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_SHOW  = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_BLANK = 7'h7F;

  typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  state_t                  state_q, state_d;
  logic [4*NUM_DIGITS-1:0] shd_data_q, shd_data_d, act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0]   shd_blank_q, shd_blank_d, act_blank_q, act_blank_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    done_q, done_d;

  logic                    wrap;
  logic [3:0]              nib;
  logic                    dig_blank;
  logic [NUM_DIGITS-1:0]   lz_mask;
`ifdef HEXLED_SCAN_LZS_EN
  logic                    zero_run;
`endif

  always_comb begin
    wrap  = (cnt_q == CNT_LAST);
    cnt_d = wrap ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    if (wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    state_d = state_q;
    case (state_q)
      ST_BLANK: if (cnt_d == CNT_SHOW) state_d = ST_SHOW;
      ST_SHOW:  if (wrap) state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase

    // A load on the boundary edge goes straight through to the active copy.
    shd_data_d  = i_load ? i_data : shd_data_q;
    shd_blank_d = i_load ? i_blank : shd_blank_q;
    act_data_d  = wrap ? shd_data_d : act_data_q;
    act_blank_d = wrap ? shd_blank_d : act_blank_q;

    lz_mask = '0;
`ifdef HEXLED_SCAN_LZS_EN
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_run   = zero_run && (act_data_q[4*k +: 4] == 4'h0);
      lz_mask[k] = zero_run;
    end
`endif

    nib       = '0;
    dig_blank = 1'b1;
    seg_d     = SEG_BLANK;
    an_d      = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        nib       = act_data_q[4*k +: 4];
        dig_blank = act_blank_q[k] | lz_mask[k];
        if (state_q == ST_SHOW) an_d[k] = 1'b0;
      end
    end
    if (state_q == ST_SHOW) begin
      seg_d = dig_blank ? SEG_BLANK : glyph(nib);
    end

    // Registered from next state so the pulse lines up with the counter itself.
    done_d = (cnt_d == CNT_LAST);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      state_q     <= ST_BLANK;
      shd_data_q  <= '0;
      shd_blank_q <= '1;
      act_data_q  <= '0;
      act_blank_q <= '1;
      seg_q       <= SEG_BLANK;
      an_q        <= '1;
      done_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      state_q     <= state_d;
      shd_data_q  <= shd_data_d;
      shd_blank_q <= shd_blank_d;
      act_data_q  <= act_data_d;
      act_blank_q <= act_blank_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      done_q      <= done_d;
    end
  end

  assign o_seg       = seg_q;
  assign o_an        = an_q;
  assign o_slot_done = done_q;

endmodule

// File: tb/tb_hexled_scan.sv
// Self-checking bench for hexled_scan (4 digits, 8-cycle slots, 2 blank cycles).
module tb_hexled_scan;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`ifdef HEXLED_SCAN_LZS_EN
  localparam bit LZS = 1'b1;
`else
  localparam bit LZS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [4*ND-1:0] i_data;
  logic            i_load;
  logic [ND-1:0]   i_blank;
  logic [6:0]      o_seg;
  logic [ND-1:0]   o_an;
  logic            o_slot_done;

  hexled_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_load(i_load),
    .i_blank(i_blank), .o_seg(o_seg), .o_an(o_an), .o_slot_done(o_slot_done)
  );

  always #5 clk = ~clk;

  typedef struct { int edge_no; logic [15:0] data; logic [3:0] blank; } ld_t;
  typedef struct { logic [15:0] data; logic [3:0] blank; logic [3:0][6:0] seg; } vec_t;

  ld_t  lq[$];
  vec_t vecs[$];
  int   e;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, e, act, exp);
    end
  endtask

  function automatic bit lz_sup(input logic [15:0] d, input int dig);
    bit lead;
    lead = (dig != 0);
    for (int k = dig; k < ND; k++) if (d[4*k +: 4] != 4'h0) lead = 1'b0;
    return LZS && lead;
  endfunction

  // Edge ee counted from reset release; display shows the slot state of edge ee-1.
  task automatic model(input int ee, output logic [3:0] an, output logic [6:0] seg,
                       output logic done);
    int p, slot, dig;
    logic [15:0] d;
    logic [3:0]  b;
    an   = 4'hF;
    seg  = 7'h7F;
    done = ((ee % SD) == SD - 1);
    if (ee >= 1) begin
      p    = ee - 1;
      slot = p / SD;
      dig  = slot % ND;
      if ((p % SD) >= BC) begin
        d = '0;
        b = '1;
        foreach (lq[i]) if (lq[i].edge_no <= slot * SD) begin
          d = lq[i].data;
          b = lq[i].blank;
        end
        an[dig] = 1'b0;
        seg = (b[dig] || lz_sup(d, dig)) ? 7'h7F : GLYPH[d[4*dig +: 4]];
      end
    end
  endtask

  task automatic check_all();
    logic [3:0] ean;
    logic [6:0] eseg;
    logic       edone;
    model(e, ean, eseg, edone);
    chk("an", 16'(o_an), 16'(ean));
    chk("seg", 16'(o_seg), 16'(eseg));
    chk("slot_done", 16'(o_slot_done), 16'(edone));
    chk("an_onehot", 16'($countones(~o_an) <= 1), 16'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    e++;
    i_load = 1'b0;
    check_all();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] b);
    i_data  = d;
    i_blank = b;
    i_load  = 1'b1;
    lq.push_back('{e + 1, d, b});
    step();
  endtask

  task automatic add_vec(input logic [15:0] d, input logic [3:0] b, input logic [6:0] s3,
                         input logic [6:0] s2, input logic [6:0] s1, input logic [6:0] s0);
    vec_t v;
    v.data  = d;
    v.blank = b;
    v.seg   = {s3, s2, s1, s0};
    vecs.push_back(v);
  endtask

  initial begin
    int s, guard;
    add_vec(16'h1A3F, 4'h0, 7'h79, 7'h08, 7'h30, 7'h0E);
    add_vec(16'h0000, 4'h5, LZS ? 7'h7F : 7'h40, 7'h7F, LZS ? 7'h7F : 7'h40, 7'h7F);
    add_vec(16'h0070, 4'h0, LZS ? 7'h7F : 7'h40, LZS ? 7'h7F : 7'h40, 7'h78, 7'h40);
    add_vec(16'h0000, 4'h0, LZS ? 7'h7F : 7'h40, LZS ? 7'h7F : 7'h40, LZS ? 7'h7F : 7'h40, 7'h40);
    add_vec(16'hEDCB, 4'h2, 7'h06, 7'h21, 7'h7F, 7'h03);
    add_vec(16'h4567, 4'h8, 7'h7F, 7'h12, 7'h02, 7'h78);
    add_vec(16'h0102, 4'h0, LZS ? 7'h7F : 7'h40, 7'h79, 7'h40, 7'h24);

    rst_n = 1'b1; i_load = 1'b0; i_data = '0; i_blank = '0; e = 0;
    #1 rst_n = 1'b0;
    #11;
    chk("rst_seg", 16'(o_seg), 16'h7F);
    chk("rst_an", 16'(o_an), 16'hF);
    chk("rst_done", 16'(o_slot_done), 16'h0);
    rst_n = 1'b1;
    repeat (20) step();

    for (int r = 0; r < vecs.size(); r++) begin
      int bnd;
      do_load(vecs[r].data, vecs[r].blank);
      bnd = ((e + SD - 1) / SD) * SD;
      for (int n = 0; n < 40; n++) begin
        int p;
        step();
        p = e - 1;
        if (p >= bnd && (p % SD) >= BC)
          chk($sformatf("vec%0d_dig%0d", r, (p / SD) % ND), 16'(o_seg),
              16'(vecs[r].seg[(p / SD) % ND]));
      end
    end

    // Load arriving mid-slot waits for the next boundary.
    do_load(16'h1111, 4'h0);
    repeat (16) step();
    while ((e % SD) != 3) step();
    s = e / SD;
    do_load(16'h2222, 4'h0);
    for (int n = 0; n < 12; n++) begin
      int p;
      step();
      p = e - 1;
      if ((p % SD) >= BC && (p / SD) == s) chk("midload_old", 16'(o_seg), 16'h79);
      if ((p % SD) >= BC && (p / SD) == s + 1) chk("midload_new", 16'(o_seg), 16'h24);
    end
    // Load on the wrap cycle takes effect in the very next slot.
    while ((e % SD) != 7) step();
    s = e / SD;
    do_load(16'h3333, 4'h0);
    for (int n = 0; n < 16; n++) begin
      int p;
      step();
      p = e - 1;
      if ((p % SD) >= BC && (p / SD) == s + 1) chk("wrapload_new", 16'(o_seg), 16'h30);
    end

    // Asynchronous reset in the middle of digit 2, with a load pending.
    guard = 0;
    while (!((e % SD) == 5 && ((e / SD) % ND) == 2) && guard < 64) begin
      step();
      guard++;
    end
    chk("reach_digit2", 16'(guard < 64), 16'd1);
    chk("pre_rst_an", 16'(o_an), 16'hB);
    i_data = 16'hFFFF; i_blank = 4'h0; i_load = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_seg", 16'(o_seg), 16'h7F);
    chk("async_rst_an", 16'(o_an), 16'hF);
    chk("async_rst_done", 16'(o_slot_done), 16'h0);
    @(posedge clk);
    #1;
    chk("held_rst_seg", 16'(o_seg), 16'h7F);
    chk("held_rst_an", 16'(o_an), 16'hF);
    i_load = 1'b0;
    rst_n = 1'b1;
    e = 0;
    lq.delete();
    repeat (24) step();
    do_load(16'hC0DE, 4'h0);
    repeat (40) step();

    for (int n = 0; n < 400; n++) begin
      logic [15:0] rd;
      logic [3:0]  rb;
      rd = 16'($urandom);
      if ($urandom_range(0, 2) == 0) rd = rd & 16'h00F0;
      rb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      if ($urandom_range(0, 5) == 0) do_load(rd, rb);
      else begin
        i_data  = rd;
        i_blank = rb;
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hexled_scan.md
HEXLED_SCAN -- requirements
Module: hexled_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed hex digits; legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000: clock cycles per digit slot; legal range >= 4.
REQ-003 Parameter BLANK_CYC, default 16: anti-ghost cycles at the start of each slot with all anodes off; legal range 1..SCAN_DIV-2.
REQ-004 i_clk  in  1: single clock; all state changes on its rising edge.
REQ-005 i_rst_n  in  1: asynchronous active-low reset.
REQ-006 i_data  in  4*NUM_DIGITS: hex nibbles; digit 0 = bits [3:0], i.e. the least significant nibble.
REQ-007 i_load  in  1: single-cycle strobe; captures i_data and i_blank into the shadow registers.
REQ-008 i_blank  in  NUM_DIGITS: per-digit force-blank mask; bit k blanks digit k.
REQ-009 o_seg  out  7: segments {g,f,e,d,c,b,a}, active-low.
REQ-010 o_an  out  NUM_DIGITS: digit enables, active-low, at most one low at any time.
REQ-011 o_slot_done  out  1: one-cycle pulse in the last cycle of each slot.

Function
REQ-012 Glyph table (value -> o_seg): 0->40, 1->79, 2->24, 3->30, 4->19, 5->12, 6->02, 7->78, 8->00, 9->10, A->08, b->03, C->46, d->21, E->06, F->0E (hex); blank = 7F.
REQ-013 Shadow registers: i_load high captures i_data/i_blank into the shadow registers at that edge.
REQ-014 Active registers: the shadow registers copy into the active registers at each slot boundary (slot counter wrap), never mid-slot.
REQ-015 Load coinciding with a boundary: i_load in the same cycle as a slot boundary makes the new value active for the slot starting at that edge.
REQ-016 Slot counter: counts 0..SCAN_DIV-1 and wraps to 0; digit index increments on wrap, NUM_DIGITS-1 -> 0.
REQ-017 o_slot_done = 1 exactly when the slot counter = SCAN_DIV-1.
REQ-018 Slot state machine with states BLANK (counter < BLANK_CYC) and SHOW (counter >= BLANK_CYC): BLANK -> SHOW at counter = BLANK_CYC; SHOW -> BLANK on counter wrap.
REQ-019 In BLANK: o_an all ones, o_seg = 7F.
REQ-020 In SHOW: o_an bit[idx] = 0, all other bits 1; o_seg = glyph of active nibble idx, or 7F if active blank bit idx = 1.
REQ-021 Outputs are registered with one-cycle latency from counter/index state; no combinational path from any input to any output.
REQ-022 NUM_DIGITS = 1: index stays 0; blanking still occurs on every wrap.

Reset
REQ-023 Reset asserted: o_seg = 7F, o_an all ones, o_slot_done = 0, slot counter = 0, index = 0, shadow and active data = 0, shadow and active blank = all ones.
REQ-024 Reset asserted mid-slot or mid-load: all outputs go to reset values immediately, without waiting for a clock edge.
REQ-025 After reset release: the first slot is digit 0, starts in BLANK, and shows blank until a load has crossed a slot boundary.

Configuration
REQ-026 Macro HEXLED_SCAN_LZS_EN defined: leading-zero suppression is active. Starting from digit NUM_DIGITS-1 and moving down, each active nibble equal to 0 displays as blank until the first non-zero nibble. Digit 0 is never suppressed. Evaluation uses the active registers.
REQ-027 Macro HEXLED_SCAN_LZS_EN undefined: no suppression; zeros display as 0 (40) subject only to i_blank.

Verification (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2)
REQ-028 Load i_data=16'h1A3F, i_blank=0, then run 40 cycles -> SHOW sequence per slot: o_an=E/o_seg=0E, D/30, B/08, 7/79; o_an=F during the first 2 cycles of every slot; o_slot_done pulses every 8 cycles.
REQ-029 Load 16'h0000 then 16'h0000 with i_blank=4'b0101 -> digits 0 and 2 show 7F; digits 1 and 3 show 40 (LZS_EN undefined).
REQ-030 LZS_EN defined, load 16'h0070 -> digits 3 and 2 show 7F, digit 1 shows 78, digit 0 shows 40; load 16'h0000 -> only digit 0 shows 40.
REQ-031 i_load with 16'h2222 at counter=3 of a slot showing 16'h1111 -> current slot still shows 79; the next slot shows 24; i_load at counter=7 -> the new value shows in the immediately following slot.
REQ-032 Assert i_rst_n low at counter=5 of digit 2 -> o_an=F, o_seg=7F in the same cycle; after release, scanning restarts at digit 0 in BLANK showing 7F until a load crosses a boundary.
REQ-033 Every cycle, assertion: o_an has at most one zero bit, and o_an = all ones whenever counter < BLANK_CYC (1-cycle-delayed view).
